// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor.
//   - digit width, largest legal digit and the +6 decimal correction
//   - bcd_digit_t, the FSM state enum
//   - nines_comp(): 9 - d, used to turn a subtraction into an addition
//   - bcd_digit_invalid(): flags a nibble that is not a decimal digit
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;
    localparam int BCD_CORR    = 6;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } bcd_state_t;

    // Illegal digits (>9) simply wrap; the result is deterministic but
    // carries no decimal meaning.
    function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
        return bcd_digit_t'(BCD_MAX) - d;
    endfunction

    function automatic logic bcd_digit_invalid(input bcd_digit_t d);
        return d > bcd_digit_t'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal correction.
// Ports:
//   a_i, b_i   : BCD digit operands
//   c_i        : carry in
//   digit_o    : corrected BCD result digit
//   c_o        : decimal carry out
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a_i,
    input  bcd_digit_t b_i,
    input  logic       c_i,
    output bcd_digit_t digit_o,
    output logic       c_o
);

    logic [4:0] t;

    always_comb begin
        t = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
        if (t > 5'(BCD_MAX)) begin
            // Adding 6 skips the six unused codes A..F; bit 4 is the carry
            // and is dropped here because c_o reports it directly.
            digit_o = bcd_digit_t'(t + 5'(BCD_CORR));
            c_o     = 1'b1;
        end else begin
            digit_o = t[3:0];
            c_o     = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Subtraction a - b - cin is computed as a + nines(b) + !cin; cout=1 then
// means no borrow, cout=0 means sum holds the ten's complement.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, sub, cin sampled once)
//   a, b                : packed BCD operands, digit 0 in bits [3:0]
//   sub, cin            : 0 = add, 1 = subtract; carry-in / borrow-in
//   out_valid/out_ready : result handshake
//   sum, cout           : packed BCD result and decimal carry / no-borrow
//   err                 : invalid digit seen in the accepted operands
//
// Build option: define BCD_DIGIT_CHECK_EN to enable the operand digit
// check behind err; otherwise err is tied low.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | one digit per cycle, index 0..DIGITS-1
// DONE  | result presented, held until out_ready
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  sub,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W     = BCD_DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    bcd_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      a_q,     a_d;
    logic [W-1:0]      b_q,     b_d;
    logic [W-1:0]      sum_q,   sum_d;
    logic              cout_q,  cout_d;

    logic [W-1:0]      b_nines;
    bcd_digit_t        a_dig, b_dig, res_dig;
    logic              res_c;
    logic              accept;

    assign accept    = (state_q == IDLE) && in_valid;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

    always_comb begin
        b_nines = '0;
        for (int i = 0; i < DIGITS; i++) begin
            b_nines[i*BCD_DIGIT_W +: BCD_DIGIT_W] = nines_comp(b[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
    end

    // Single digit adder time-shared across all digit positions.
    assign a_dig = a_q[{idx_q, 2'b00} +: BCD_DIGIT_W];
    assign b_dig = b_q[{idx_q, 2'b00} +: BCD_DIGIT_W];

    bcd_digit_add u_digit_add (
        .a_i     (a_dig),
        .b_i     (b_dig),
        .c_i     (carry_q),
        .digit_o (res_dig),
        .c_o     (res_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? b_nines : b;
                    carry_d = sub ? ~cin : cin;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d[{idx_q, 2'b00} +: BCD_DIGIT_W] = res_dig;
                carry_d = res_c;
                if (idx_q == LAST_IDX) begin
                    cout_d  = res_c;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                // The cycle that completes the output handshake never accepts.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic err_q, err_d;
    logic raw_bad;

    always_comb begin
        raw_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            raw_bad = raw_bad
                    | bcd_digit_invalid(a[i*BCD_DIGIT_W +: BCD_DIGIT_W])
                    | bcd_digit_invalid(b[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
    end

    // Checks the raw b, not the nines-complemented copy.
    assign err_d = accept ? raw_bad : err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
module tb_bcd_serial_addsub;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
`ifdef BCD_DIGIT_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         sub, cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int checks   = 0;
    int failures = 0;
    int lat;

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents operands at a negedge, lets the next posedge accept them,
    // then scrambles the inputs to show they are not re-sampled.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic s, input logic c);
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a = av; b = bv; sub = s; cin = c; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'h3141; b = 16'h5926; sub = ~s; cin = ~c;
        check("in_ready_calc", {31'd0, in_ready}, 32'd0);
    endtask

    // Counts posedges after acceptance until out_valid, bounded.
    task automatic wait_result(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", {31'd0, out_valid}, 32'd0);
        check("in_ready_back", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic s, input logic c,
                          input logic [W-1:0] esum, input logic ecout, input logic eerr);
        int n;
        start_op(av, bv, s, c);
        wait_result(n);
        check({tag, "_lat"}, n, DIGITS);
        check({tag, "_sum"}, {16'd0, sum}, {16'd0, esum});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ecout});
        check({tag, "_err"}, {31'd0, err}, {31'd0, eerr});
        finish_op();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;

        run_op("add0999", 16'h0999, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("add9999", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add4567", 16'h4567, 16'h5432, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op("add_cin", 16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0);
        run_op("sub_pos", 16'h0500, 16'h0123, 1'b1, 1'b0, 16'h0377, 1'b1, 1'b0);
        run_op("sub_neg", 16'h0123, 16'h0500, 1'b1, 1'b0, 16'h9623, 1'b0, 1'b0);
        run_op("sub_bin", 16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0998, 1'b1, 1'b0);
        run_op("sub_eq",  16'h0042, 16'h0042, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Backpressure: result held while out_ready is low, new operands ignored.
        start_op(16'h0500, 16'h0123, 1'b1, 1'b0);
        wait_result(lat);
        check("bp_lat", lat, DIGITS);
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_sum", {16'd0, sum}, 32'h0377);
            check("bp_cout", {31'd0, cout}, 32'd1);
        end
        in_valid = 1'b0;
        finish_op();

        // Reset two cycles into CALC aborts the operation.
        start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_sum", {16'd0, sum}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Invalid digit: arithmetic follows the digit rule, err only with the check built in.
        run_op("bad_digit", 16'h00A0, 16'h0001, 1'b0, 1'b0, 16'h0101, 1'b0, CHK);
        run_op("err_clear", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
